// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32IM core front end: widths, the canonical NOP and
// the fetch-sequencer state encoding.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer holding a fetched instruction and its PC while decode is stalled.
module fetch_hold_buf
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic            valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc
);

    // Clear wins over load so a redirect can never leave stale data behind.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr <= RV_NOP;
            pc    <= '0;
        end else if (load && !clear) begin
            instr <= instr_in;
            pc    <= pc_in;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// IF-stage sequencer: owns the PC, issues single-outstanding imem requests and feeds IF/ID.
// Optional FETCH_PERF_CNT_EN adds delivered-instruction and stall-cycle counters.
module fetch_controller
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst,
    // Request transfers on a cycle with valid & ready; valid/addr hold until then,
    // except on redirect or rst. Exactly one response per accepted request.
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ir_enable,
    output logic [XLEN-1:0] ir_instruction,
    output logic [XLEN-1:0] ir_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] pc_inflight, inflight_next;
    logic            discard, discard_next;
    logic            buf_load, buf_clear, buf_valid;
    logic [XLEN-1:0] buf_instr, buf_pc;
    logic [XLEN-1:0] redirect_target;
    logic            delivered;

    fetch_hold_buf u_hold_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (buf_load),
        .clear    (buf_clear),
        .instr_in (imem_rsp_data),
        .pc_in    (pc_inflight),
        .valid    (buf_valid),
        .instr    (buf_instr),
        .pc       (buf_pc)
    );

    assign redirect_target = align_pc(redirect_pc);
    assign imem_req_addr   = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= REQ;
            pc          <= RESET_VECTOR;
            pc_inflight <= RESET_VECTOR;
            discard     <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            pc_inflight <= inflight_next;
            discard     <= discard_next;
        end
    end

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        inflight_next  = pc_inflight;
        discard_next   = discard;
        buf_load       = 1'b0;
        buf_clear      = 1'b0;
        delivered      = 1'b0;
        imem_req_valid = 1'b0;
        ir_enable      = 1'b0;
        ir_instruction = RV_NOP;
        ir_pc          = pc;

        case (state)
            REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    state_next    = WAIT;
                    inflight_next = pc;
                    // A request accepted in the redirect cycle is already in flight.
                    if (redirect_valid) discard_next = 1'b1;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    if (imem_rsp_valid) begin
                        state_next   = REQ;
                        discard_next = 1'b0;
                    end else begin
                        discard_next = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (discard) begin
                        state_next   = REQ;
                        discard_next = 1'b0;
                    end else if (!stall) begin
                        state_next     = REQ;
                        ir_enable      = 1'b1;
                        ir_instruction = imem_rsp_data;
                        ir_pc          = pc_inflight;
                        pc_next        = pc_inflight + 32'd4;
                        delivered      = 1'b1;
                    end else begin
                        state_next = HOLD;
                        buf_load   = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    state_next = REQ;
                end else if (!stall) begin
                    state_next     = REQ;
                    ir_enable      = buf_valid;
                    ir_instruction = buf_instr;
                    ir_pc          = buf_pc;
                    pc_next        = buf_pc + 32'd4;
                    buf_clear      = 1'b1;
                    delivered      = buf_valid;
                end
            end
            default: state_next = REQ;
        endcase

        // Redirect overrides every state's delivery and loads a bubble instead.
        if (redirect_valid) begin
            pc_next        = redirect_target;
            ir_enable      = 1'b1;
            ir_instruction = RV_NOP;
            ir_pc          = redirect_target;
            buf_clear      = 1'b1;
            delivered      = 1'b0;
        end

        if (rst) begin
            imem_req_valid = 1'b0;
            ir_enable      = 1'b0;
            ir_instruction = RV_NOP;
            ir_pc          = RESET_VECTOR;
            delivered      = 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (delivered) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (state == HOLD || (state == WAIT && stall))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a one-outstanding, one-cycle memory model.
module tb_fetch_controller;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ir_enable;
    logic [31:0] ir_instruction;
    logic [31:0] ir_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          pend     = 1'b0;
    bit          mem_go   = 1'b1;
    logic [31:0] pend_addr = '0;

    fetch_controller #(.RESET_VECTOR(32'h0000_0000), .XLEN(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ir_enable      (ir_enable),
        .ir_instruction (ir_instruction),
        .ir_pc          (ir_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h0BAD_0000 ^ addr;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_rsp();
        imem_rsp_valid = pend && mem_go;
        imem_rsp_data  = pend ? mem_word(pend_addr) : 32'h0;
    endtask

    task automatic settle();
        #1;
    endtask

    // Samples the handshakes of the ending cycle, then advances the memory model.
    task automatic tick();
        logic        hs;
        logic        fired;
        logic [31:0] addr;
        hs    = imem_req_valid && imem_req_ready;
        fired = imem_rsp_valid;
        addr  = imem_req_addr;
        @(posedge clk);
        #1;
        if (fired) pend = 1'b0;
        if (hs) begin
            pend      = 1'b1;
            pend_addr = addr;
        end
        if (rst) pend = 1'b0;
        drive_rsp();
    endtask

    initial begin
        rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        // Reset cycle outputs
        tick(); tick(); settle();
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_ir_enable", {31'b0, ir_enable}, 32'd0);
        check("rst_ir_instr", ir_instruction, 32'h0000_0013);
        check("rst_ir_pc", ir_pc, 32'h0);

        // Zero-wait streaming: 0x0, 0x4, 0x8 on alternate cycles
        rst = 1'b0; settle();
        check("t1_req_valid0", {31'b0, imem_req_valid}, 32'd1);
        check("t1_addr0", imem_req_addr, 32'h0);
        tick(); settle();
        check("t1_ir_en0", {31'b0, ir_enable}, 32'd1);
        check("t1_ir_pc0", ir_pc, 32'h0);
        check("t1_ir_instr0", ir_instruction, 32'h0BAD_0000);
        check("t1_wait_no_req", {31'b0, imem_req_valid}, 32'd0);
        tick(); settle();
        check("t1_addr4", imem_req_addr, 32'h4);

        // Backpressure: request held stable while not ready
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t2_hold_valid", {31'b0, imem_req_valid}, 32'd1);
            check("t2_hold_addr", imem_req_addr, 32'h4);
            tick();
        end
        imem_req_ready = 1'b1; settle();
        check("t2_addr_at_accept", imem_req_addr, 32'h4);
        tick(); settle();
        check("t2_ir_pc4", ir_pc, 32'h4);
        check("t2_ir_instr4", ir_instruction, 32'h0BAD_0004);
        tick(); settle();

        // Decode stall on the 0x8 response, held four cycles
        check("t3_addr8", imem_req_addr, 32'h8);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("t3_stalled_ir_en", {31'b0, ir_enable}, 32'd0);
            check("t3_stalled_no_req", {31'b0, imem_req_valid}, 32'd0);
            tick();
        end
        stall = 1'b0; settle();
        check("t3_release_ir_en", {31'b0, ir_enable}, 32'd1);
        check("t3_release_instr", ir_instruction, 32'h0BAD_0008);
        check("t3_release_pc", ir_pc, 32'h8);
        tick(); settle();

        // Redirect while waiting for 0xC: bubble, 0xC data dropped, next fetch 0x100
        check("t4_addrC", imem_req_addr, 32'hC);
        mem_go = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h100; settle();
        check("t4_bubble_en", {31'b0, ir_enable}, 32'd1);
        check("t4_bubble_nop", ir_instruction, 32'h0000_0013);
        tick();
        redirect_valid = 1'b0; mem_go = 1'b1; drive_rsp(); settle();
        check("t4_stale_dropped", {31'b0, ir_enable}, 32'd0);
        check("t4_stale_no_req", {31'b0, imem_req_valid}, 32'd0);
        tick(); settle();
        check("t4_target_valid", {31'b0, imem_req_valid}, 32'd1);
        check("t4_target_addr", imem_req_addr, 32'h100);

        // Redirect in the same cycle as a response: response never reaches IR
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h200; settle();
        check("t4b_bubble_en", {31'b0, ir_enable}, 32'd1);
        check("t4b_bubble_nop", ir_instruction, 32'h0000_0013);
        tick();
        redirect_valid = 1'b0; settle();
        check("t4b_target_addr", imem_req_addr, 32'h200);

        // Redirect while held by stall: bubble, buffer emptied, fetch from target
        tick();
        stall = 1'b1; settle();
        check("t5_capture_ir_en", {31'b0, ir_enable}, 32'd0);
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h300; settle();
        check("t5_bubble_en", {31'b0, ir_enable}, 32'd1);
        check("t5_bubble_nop", ir_instruction, 32'h0000_0013);
        tick();
        redirect_valid = 1'b0; settle();
        check("t5_target_addr", imem_req_addr, 32'h300);
        check("t5_no_stale_ir", {31'b0, ir_enable}, 32'd0);
        stall = 1'b0;
        tick(); settle();
        check("t5_target_pc", ir_pc, 32'h300);
        check("t5_target_instr", ir_instruction, 32'h0BAD_0300);
        tick(); settle();

        // Unaligned redirect to top of memory, then PC wrap to 0
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; settle();
        check("t6_addr_redirect_cycle", imem_req_addr, 32'h304);
        check("t6_bubble_nop", ir_instruction, 32'h0000_0013);
        tick();
        redirect_valid = 1'b0; imem_req_ready = 1'b1; settle();
        check("t6_aligned_target", imem_req_addr, 32'hFFFF_FFFC);
        tick(); settle();
        check("t6_top_pc", ir_pc, 32'hFFFF_FFFC);
        check("t6_top_instr", ir_instruction, 32'hF452_FFFC);
        tick(); settle();
        check("t6_wrap_addr", imem_req_addr, 32'h0);

        // Reset mid-WAIT, then a stray response is ignored
        mem_go = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF; settle();
        check("t7_stray_ignored", {31'b0, ir_enable}, 32'd0);
        check("t7_restart_addr", imem_req_addr, 32'h0);
        mem_go = 1'b1;
        tick(); settle();
        check("t7_refetch_pc", ir_pc, 32'h0);
        check("t7_refetch_instr", ir_instruction, 32'h0BAD_0000);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
